// File: rtl/soc_evt_pkg.sv
// soc_evt_pkg
//   Shared types and default widths for the SoC-to-cluster event collector.
//   evt_t      : event id at the default width
//   evt_mode_e : full-FIFO policy (stall the sources, or accept and discard)
package soc_evt_pkg;

  localparam int EVNT_WIDTH_DEF = 8;
  localparam int DEPTH_DEF      = 8;
  localparam int OVF_WIDTH_DEF  = 16;

  typedef logic [EVNT_WIDTH_DEF-1:0] evt_t;

  typedef enum logic {
    EVT_STALL = 1'b0,
    EVT_DROP  = 1'b1
  } evt_mode_e;

endpackage

// File: rtl/soc_evt_rr_arb.sv
// soc_evt_rr_arb
//   N-way round-robin arbiter. It grants at most one requester per cycle,
//   searching from the priority pointer upward. After a grant to i, the
//   pointer moves to (i+1) mod N_SRC. With no grant, the pointer holds.
// Ports
//   clk, rst : clock, synchronous active-high reset (pointer -> 0)
//   en       : grant permitted this cycle
//   req      : per-source request
//   gnt      : one-hot grant (combinational)
//   idx      : index of the granted source (valid when |gnt)
module soc_evt_rr_arb #(
  parameter  int N_SRC = 4,
  localparam int IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [N_SRC-1:0] req,
  output logic [N_SRC-1:0] gnt,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] ptr;
  logic             found;
  int               cand;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int k = 0; k < N_SRC; k++) begin
      cand = (int'(ptr) + k) % N_SRC;
      if (en && !found && req[cand]) begin
        found     = 1'b1;
        gnt[cand] = 1'b1;
        idx       = IDX_W'(cand);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (|gnt) begin
      ptr <= (idx == IDX_W'(N_SRC - 1)) ? '0 : idx + 1'b1;
    end
  end

endmodule

// File: rtl/soc_evt_collector.sv
// soc_evt_collector
//   Merges N_SRC valid/ack event sources into one buffered event stream.
//   It uses round-robin arbitration into a DEPTH-entry register FIFO. When
//   the FIFO is full, the block either stalls the sources or accepts and
//   discards the event. A saturating counter records the discarded events.
// Ports
//   clk_i, rst_i  : clock, synchronous active-high reset
//   en_i          : grant enable (the FIFO drains regardless)
//   src_valid_i   : per-source request, held until acknowledged
//   src_data_i    : per-source event id, source s at [s*EVNT_WIDTH +: EVNT_WIDTH]
//   src_ack_o     : one-hot acceptance pulse, same cycle as the write
//   evt_valid_o   : FIFO head valid
//   evt_data_o    : FIFO head event id (0 when empty)
//   evt_ready_i   : consumer takes the head
//   fill_o        : FIFO occupancy
//   ovf_cnt_o     : saturating count of discarded events
//   clr_ovf_i     : clears the overflow count
module soc_evt_collector
  import soc_evt_pkg::*;
#(
  parameter int N_SRC        = 4,
  parameter int EVNT_WIDTH   = EVNT_WIDTH_DEF,
  parameter int DEPTH        = DEPTH_DEF,
  parameter int DROP_ON_FULL = 0,
  parameter int OVF_WIDTH    = OVF_WIDTH_DEF
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          en_i,
  input  logic [N_SRC-1:0]              src_valid_i,
  input  logic [N_SRC*EVNT_WIDTH-1:0]   src_data_i,
  output logic [N_SRC-1:0]              src_ack_o,
  output logic                          evt_valid_o,
  output logic [EVNT_WIDTH-1:0]         evt_data_o,
  input  logic                          evt_ready_i,
  output logic [$clog2(DEPTH+1)-1:0]    fill_o,
  output logic [OVF_WIDTH-1:0]          ovf_cnt_o,
  input  logic                          clr_ovf_i
);

  localparam int        IDX_W = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int        AW    = $clog2(DEPTH);
  localparam int        FW    = $clog2(DEPTH + 1);
  localparam evt_mode_e MODE  = (DROP_ON_FULL != 0) ? EVT_DROP : EVT_STALL;

  function automatic logic [OVF_WIDTH-1:0] sat_inc(input logic [OVF_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic [EVNT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [FW-1:0]         fill;
  logic [OVF_WIDTH-1:0]  ovf_cnt;

  logic                  full;
  logic                  pop;
  logic                  space;
  logic                  arb_en;
  logic [N_SRC-1:0]      gnt;
  logic [IDX_W-1:0]      gnt_idx;
  logic                  granted;
  logic                  push;
  logic                  drop;
  logic [EVNT_WIDTH-1:0] wr_data;

  assign full  = (fill == FW'(DEPTH));
  assign pop   = evt_valid_o & evt_ready_i;
  // A pop frees the slot in the same cycle, so a full FIFO can still accept.
  assign space = !full | pop;

  // In drop mode the source is acknowledged even without space. Reset
  // suppresses grants so that no acknowledge is issued while rst_i is high.
  assign arb_en = en_i & !rst_i & ((MODE == EVT_DROP) | space);

  soc_evt_rr_arb #(
    .N_SRC (N_SRC)
  ) u_arb (
    .clk (clk_i),
    .rst (rst_i),
    .en  (arb_en),
    .req (src_valid_i),
    .gnt (gnt),
    .idx (gnt_idx)
  );

  assign granted = |gnt;
  assign push    = granted & space;
  assign drop    = granted & !space;
  assign wr_data = src_data_i[gnt_idx*EVNT_WIDTH +: EVNT_WIDTH];

  // FIFO storage: data only, never reset; occupancy tracks what is valid
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // FIFO control: pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fill   <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fill <= fill + 1'b1;
        2'b01:   fill <= fill - 1'b1;
        default: fill <= fill;
      endcase
    end
  end

  // Overflow count: a clear and a drop in the same cycle leaves exactly one
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ovf_cnt <= '0;
    end else if (clr_ovf_i) begin
      ovf_cnt <= drop ? OVF_WIDTH'(1) : '0;
    end else if (drop) begin
      ovf_cnt <= sat_inc(ovf_cnt);
    end
  end

  assign src_ack_o   = gnt;
  assign evt_valid_o = (fill != '0);
  assign evt_data_o  = evt_valid_o ? mem[rd_ptr] : '0;
  assign fill_o      = fill;
  assign ovf_cnt_o   = ovf_cnt;

endmodule

// File: tb/tb_soc_evt_collector.sv
// tb_soc_evt_collector
//   This is a directed bench for soc_evt_collector. One instance runs in
//   stall mode and one in drop-on-full mode. They share the clock and reset.
//   The bench sets inputs just after the falling edge and samples outputs
//   1 time unit later, well before the next rising edge.
module tb_soc_evt_collector;

  logic        clk;
  logic        rst;

  logic        s_en, s_ready, s_clr;
  logic [3:0]  s_valid, s_ack;
  logic [31:0] s_data;
  logic        s_evt_valid;
  logic [7:0]  s_evt_data;
  logic [3:0]  s_fill;
  logic [15:0] s_ovf;

  logic        d_en, d_ready, d_clr;
  logic [3:0]  d_valid, d_ack;
  logic [31:0] d_data;
  logic        d_evt_valid;
  logic [7:0]  d_evt_data;
  logic [3:0]  d_fill;
  logic [15:0] d_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  soc_evt_collector #(.DROP_ON_FULL(0)) dut_s (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (s_en),
    .src_valid_i (s_valid),
    .src_data_i  (s_data),
    .src_ack_o   (s_ack),
    .evt_valid_o (s_evt_valid),
    .evt_data_o  (s_evt_data),
    .evt_ready_i (s_ready),
    .fill_o      (s_fill),
    .ovf_cnt_o   (s_ovf),
    .clr_ovf_i   (s_clr)
  );

  soc_evt_collector #(.DROP_ON_FULL(1)) dut_d (
    .clk_i       (clk),
    .rst_i       (rst),
    .en_i        (d_en),
    .src_valid_i (d_valid),
    .src_data_i  (d_data),
    .src_ack_o   (d_ack),
    .evt_valid_o (d_evt_valid),
    .evt_data_o  (d_evt_data),
    .evt_ready_i (d_ready),
    .fill_o      (d_fill),
    .ovf_cnt_o   (d_ovf),
    .clr_ovf_i   (d_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1;
    s_en = 1'b1; s_ready = 1'b0; s_clr = 1'b0; s_valid = 4'hF; s_data = '0;
    d_en = 1'b1; d_ready = 1'b0; d_clr = 1'b0; d_valid = 4'h0; d_data = '0;

    // Reset with every source requesting
    @(negedge clk);
    #1;
    chk("rst_ack", 32'(s_ack), 32'h0);
    chk("rst_evt_valid", 32'(s_evt_valid), 32'h0);
    chk("rst_evt_data", 32'(s_evt_data), 32'h0);
    chk("rst_fill", 32'(s_fill), 32'h0);
    chk("rst_ovf", 32'(s_ovf), 32'h0);
    chk("rst_d_fill", 32'(d_fill), 32'h0);

    // Round robin with all four sources requesting and the consumer ready
    @(negedge clk);
    rst = 1'b0;
    s_ready = 1'b1;
    s_data = {8'h33, 8'h22, 8'h11, 8'h00};
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("rr_ack", 32'(s_ack), 32'(4'b0001 << (i % 4)));
      if (i == 0) chk("rr_empty", 32'(s_evt_valid), 32'h0);
      else        chk("rr_out", 32'(s_evt_data), 32'((i - 1) * 8'h11));
      @(negedge clk);
    end
    s_valid = 4'h0;
    #1;
    chk("rr_tail", 32'(s_evt_data), 32'h00);
    @(negedge clk);
    chk("rr_drained", 32'(s_fill), 32'h0);

    // Stall mode: source 0 streams nine events into a stopped consumer
    s_ready = 1'b0;
    s_valid = 4'b0001;
    for (int k = 0; k < 8; k++) begin
      s_data[7:0] = 8'(8'hA0 + k);
      #1;
      chk("stall_ack", 32'(s_ack), 32'h1);
      @(negedge clk);
    end
    s_data[7:0] = 8'hA8;
    #1;
    chk("stall_full_ack", 32'(s_ack), 32'h0);
    chk("stall_fill", 32'(s_fill), 32'h8);
    @(negedge clk);
    #1;
    chk("stall_hold_ack", 32'(s_ack), 32'h0);
    s_ready = 1'b1;
    #1;
    chk("stall_pop_ack", 32'(s_ack), 32'h1);
    chk("stall_head", 32'(s_evt_data), 32'hA0);
    @(negedge clk);
    chk("stall_fill_kept", 32'(s_fill), 32'h8);
    s_valid = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("stall_order", 32'(s_evt_data), 32'(8'hA0 + k));
      @(negedge clk);
    end
    chk("stall_empty", 32'(s_fill), 32'h0);

    // Full FIFO with simultaneous push and pop, source 2
    s_ready = 1'b0;
    s_valid = 4'b0100;
    for (int k = 0; k < 8; k++) begin
      s_data[23:16] = 8'(8'hB0 + k);
      #1;
      chk("pp_fill_ack", 32'(s_ack), 32'h4);
      @(negedge clk);
    end
    s_data[23:16] = 8'hB8;
    s_ready = 1'b1;
    #1;
    chk("pp_ack", 32'(s_ack), 32'h4);
    chk("pp_head", 32'(s_evt_data), 32'hB0);
    @(negedge clk);
    chk("pp_fill", 32'(s_fill), 32'h8);
    s_valid = 4'h0;
    for (int k = 1; k <= 8; k++) begin
      #1;
      chk("pp_order", 32'(s_evt_data), 32'(8'hB0 + k));
      @(negedge clk);
    end
    chk("pp_empty", 32'(s_fill), 32'h0);

    // Drop mode: fill with source 1, then three discarded events and a clear
    d_valid = 4'b0010;
    for (int k = 0; k < 8; k++) begin
      d_data[15:8] = 8'(8'hD0 + k);
      #1;
      chk("drop_fill_ack", 32'(d_ack), 32'h2);
      @(negedge clk);
    end
    for (int k = 0; k < 3; k++) begin
      d_data[15:8] = 8'(8'hE0 + k);
      #1;
      chk("drop_ack", 32'(d_ack), 32'h2);
      @(negedge clk);
    end
    chk("drop_fill", 32'(d_fill), 32'h8);
    chk("drop_ovf", 32'(d_ovf), 32'h3);
    d_clr = 1'b1;
    #1;
    chk("drop_clr_ack", 32'(d_ack), 32'h2);
    @(negedge clk);
    d_clr = 1'b0;
    d_valid = 4'h0;
    chk("drop_clr_ovf", 32'(d_ovf), 32'h1);
    chk("drop_head", 32'(d_evt_data), 32'hD0);

    // en low: buffered events still drain, no new grants
    s_ready = 1'b0;
    s_valid = 4'b1000;
    for (int k = 0; k < 3; k++) begin
      s_data[31:24] = 8'(8'hC0 + k);
      #1;
      chk("en_load_ack", 32'(s_ack), 32'h8);
      @(negedge clk);
    end
    s_en = 1'b0;
    s_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("en_off_ack", 32'(s_ack), 32'h0);
      chk("en_off_data", 32'(s_evt_data), 32'(8'hC0 + k));
      @(negedge clk);
    end
    chk("en_off_fill", 32'(s_fill), 32'h0);
    chk("en_off_valid", 32'(s_evt_valid), 32'h0);

    // Reset in the middle of a burst
    s_en = 1'b1;
    s_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      chk("burst_ack", 32'(s_ack), 32'h8);
      @(negedge clk);
    end
    chk("burst_fill", 32'(s_fill), 32'h3);
    rst = 1'b1;
    #1;
    chk("mid_rst_ack", 32'(s_ack), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    s_valid = 4'h0;
    chk("mid_rst_fill", 32'(s_fill), 32'h0);
    chk("mid_rst_valid", 32'(s_evt_valid), 32'h0);
    chk("mid_rst_d_ovf", 32'(d_ovf), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
